// File: rtl/sorted_cache_pkg.sv
// Shared constants for the sorted key/value cache: FSM encodings and the
// width helper for lo/hi/mid/count (one bit wider than an entry index).
package sorted_cache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_INSERT = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    function automatic int idx_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sorted_cache_searcher.sv
// Half-open [lo,hi) binary search over the sorted key array; the caller
// feeds back the key at mid each cycle.
module sorted_cache_searcher
    import sorted_cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int IW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [IW-1:0]     count,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] mid_key,
    output logic              done,
    output logic              hit,
    output logic [IW-1:0]     index,
    output logic [IW-1:0]     mid
);

    logic [IW-1:0] lo_q, lo_d;
    logic [IW-1:0] hi_q, hi_d;
    logic [IW:0]   sum;

    // Extra bit keeps lo+hi exact even at the top of the range.
    assign sum   = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid   = sum[IW:1];
    assign done  = (lo_q == hi_q);
    assign hit   = !done && (mid_key == addr);
    assign index = done ? lo_q : mid;

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (start) begin
            lo_d = '0;
            hi_d = count;
        end else if (step && !done && !hit) begin
            if (mid_key < addr) begin
                lo_d = mid + 1'b1;
            end else begin
                hi_d = mid;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/sorted_cache.sv
// Sorted key/value cache: binary-search lookup, in-place write-hit update and
// one-cycle parallel shift-insert with largest-key eviction when full.
module sorted_cache
    import sorted_cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int IW    = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_evict,
    output logic [DATA_W-1:0] resp_data,
    output logic [IW-1:0]     count,
    output logic              full
);

    localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);

    state_t              state_q, state_d;
    logic [IW-1:0]       count_q, count_d;
    logic                req_write_q, req_write_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic                resp_hit_q, resp_hit_d;
    logic                resp_evict_q, resp_evict_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;

    logic [ADDR_W-1:0]   key_q  [DEPTH];
    logic [ADDR_W-1:0]   key_d  [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];

    logic                srch_start, srch_done, srch_hit;
    logic [IW-1:0]       srch_index, srch_mid, ins_pos;
    logic [ADDR_W-1:0]   mid_key;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_hit   = resp_hit_q;
    assign resp_evict = resp_evict_q;
    assign resp_data  = resp_data_q;
    assign count      = count_q;
    assign full       = (count_q == DEPTH_I);

    assign srch_start = (state_q == ST_IDLE) && req_valid;
    assign mid_key    = key_q[srch_mid[IW-2:0]];
    // Insertion past the last slot of a full array lands on the last slot.
    assign ins_pos    = (srch_index == DEPTH_I) ? DEPTH_I - 1'b1 : srch_index;

    sorted_cache_searcher #(
        .ADDR_W (ADDR_W),
        .IW     (IW)
    ) u_searcher (
        .clk     (clk),
        .reset   (reset),
        .start   (srch_start),
        .step    (state_q == ST_SEARCH),
        .count   (count_q),
        .addr    (req_addr_q),
        .mid_key (mid_key),
        .done    (srch_done),
        .hit     (srch_hit),
        .index   (srch_index),
        .mid     (srch_mid)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [IW-1:0] GI = IW'(gi);
        logic [ADDR_W-1:0] key_below;
        logic [DATA_W-1:0] data_below;
        logic              do_ins, do_shift, do_upd;

        if (gi == 0) begin : g_first
            assign key_below  = '0;
            assign data_below = '0;
        end else begin : g_rest
            assign key_below  = key_q[gi-1];
            assign data_below = data_q[gi-1];
        end

        // Entries above the insertion point move up; the top one falls off when full.
        assign do_ins   = (state_q == ST_INSERT) && (GI == ins_pos);
        assign do_shift = (state_q == ST_INSERT) && (GI > ins_pos);
        assign do_upd   = (state_q == ST_SEARCH) && srch_hit && req_write_q && (srch_mid == GI);

        assign key_d[gi]  = do_ins ? req_addr_q : (do_shift ? key_below : key_q[gi]);
        assign data_d[gi] = (do_ins || do_upd) ? req_data_q
                          : (do_shift ? data_below : data_q[gi]);
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        resp_hit_d   = resp_hit_q;
        resp_evict_d = resp_evict_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_write_d = req_write;
                    req_addr_d  = req_addr;
                    req_data_d  = req_data;
                    state_d     = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (srch_hit) begin
                    resp_hit_d   = 1'b1;
                    resp_evict_d = 1'b0;
                    resp_data_d  = req_write_q ? '0 : data_q[srch_mid[IW-2:0]];
                    state_d      = ST_RESP;
                end else if (srch_done) begin
                    resp_hit_d   = 1'b0;
                    resp_evict_d = 1'b0;
                    resp_data_d  = '0;
                    state_d      = req_write_q ? ST_INSERT : ST_RESP;
                end
            end
            ST_INSERT: begin
                resp_evict_d = full;
                if (!full) begin
                    count_d = count_q + 1'b1;
                end
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            resp_hit_q   <= 1'b0;
            resp_evict_q <= 1'b0;
            resp_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            resp_hit_q   <= resp_hit_d;
            resp_evict_q <= resp_evict_d;
            resp_data_q  <= resp_data_d;
            key_q        <= key_d;
            data_q       <= data_d;
        end
    end

endmodule
